// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux selects and the control word handed from decode to the top.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_ALUWB    = 4'd8,
        S_IMMEXEC  = 4'd9,
        S_IMMWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD       = 2'b00;
    localparam logic [1:0] ALU_SUB       = 2'b01;
    localparam logic [1:0] ALU_FUNCT     = 2'b10;
    localparam logic [1:0] ALU_IMM_LOGIC = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       ext_zero;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    // andi/ori zero-extend and use the opcode-selected logical ALU op
    function automatic logic is_imm_logic(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control word from FSM state, latched opcode and mem_ready.
// mem_ready only matters in FETCH, where it qualifies the IR and PC loads.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    logic imm_logic;
    assign imm_logic = is_imm_logic(opcode_i);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ASB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = ASB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_IMM;
            end
            S_MEMREAD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_IMMEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_IMM;
                ctrl_o.ext_zero  = imm_logic;
                ctrl_o.alu_op    = imm_logic ? ALU_IMM_LOGIC : ALU_ADD;
            end
            // extender/ALU selects stay put so ALUOut is not disturbed
            S_IMMWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.ext_zero  = imm_logic;
                ctrl_o.alu_op    = imm_logic ? ALU_IMM_LOGIC : ALU_ADD;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_B;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_src    = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PC_JUMP;
            end
            S_ILLEGAL: ctrl_o.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: state register, opcode latch and next-state
// logic; the control word itself comes from ctrl_decode.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       ext_zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // the live opcode is only trusted during DECODE
    assign opcode_d = (state_q == S_DECODE) ? opcode : opcode_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYPE:                 state_d = S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEXEC;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_IMMEXEC:  state_d = S_IMMWB;
            S_IMMWB, S_BRANCH, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign ext_zero   = ctrl.ext_zero;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction phase model, directed
// table, randomized instruction stream and an asynchronous reset mid-stall.
module tb_multicycle_controller;

    logic       clk, reset_n, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, ext_zero, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .ext_zero(ext_zero),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [17:0] cw_t;
    cw_t act;
    assign act = {pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, ext_zero, alu_src_a, alu_src_b, alu_op,
                  pc_src, illegal};

    int n_vec = 0;
    int n_err = 0;

    // Reference: each instruction is a list of named phases with fixed outputs
    typedef enum int {P_FETCH, P_DEC, P_ADDR, P_RD, P_MWB, P_WR, P_EX, P_AWB,
                      P_IEX, P_IWB, P_BR, P_J, P_ILL} phase_e;

    function automatic cw_t mk(input bit pcw, br, io, mr, mw, irw, rdst, m2r, rw,
                               ez, asa, input bit [1:0] asb, aop, psrc,
                               input bit ill);
        return {pcw, br, io, mr, mw, irw, rdst, m2r, rw, ez, asa, asb, aop, psrc, ill};
    endfunction

    function automatic bit is_logic_imm(input logic [5:0] op);
        return op == 6'b001100 || op == 6'b001101;
    endfunction

    function automatic cw_t expect_cw(input phase_e p, input logic [5:0] op, input bit rdy);
        bit lg;
        lg = is_logic_imm(op);
        case (p)
            P_FETCH: return mk(rdy,0,0,1,0,rdy,0,0,0,0,0,2'b01,2'b00,2'b00,0);
            P_DEC:   return mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
            P_ADDR:  return mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
            P_RD:    return mk(0,0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
            P_MWB:   return mk(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0);
            P_WR:    return mk(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
            P_EX:    return mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
            P_AWB:   return mk(0,0,0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0);
            P_IEX:   return mk(0,0,0,0,0,0,0,0,0,lg,1,2'b10,lg ? 2'b11 : 2'b00,2'b00,0);
            P_IWB:   return mk(0,0,0,0,0,0,0,0,1,lg,0,2'b00,lg ? 2'b11 : 2'b00,2'b00,0);
            P_BR:    return mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
            P_J:     return mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
            default: return mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);
        endcase
    endfunction

    // phases following FETCH and DECODE for a given opcode
    function automatic void tail(input logic [5:0] op, output phase_e q[$]);
        q = {};
        case (op)
            6'b100011: q = '{P_ADDR, P_RD, P_MWB};
            6'b101011: q = '{P_ADDR, P_WR};
            6'b000000: q = '{P_EX, P_AWB};
            6'b001000, 6'b001100, 6'b001101: q = '{P_IEX, P_IWB};
            6'b000100: q = '{P_BR};
            6'b000010: q = '{P_J};
            default:   q = '{P_ILL};
        endcase
    endfunction

    function automatic int base_cycles(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101: return 4;
            default:   return 3;
        endcase
    endfunction

    task automatic check(input string nm, input cw_t a, input cw_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // one cycle: drive, settle, compare, advance to just past the next edge
    task automatic step(input bit rdy, input logic [5:0] op, input cw_t e, input string nm);
        mem_ready = rdy;
        opcode    = op;
        #2;
        check(nm, act, e);
        @(posedge clk);
        #1;
    endtask

    // runs one instruction starting in FETCH; opcode is garbage outside DECODE
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                             output int cyc);
        phase_e q[$];
        string  nm;
        cyc = 0;
        nm = $sformatf("op%06b", op);
        for (int i = 0; i < fst; i++) begin
            step(1'b0, 6'($urandom), expect_cw(P_FETCH, op, 1'b0), {nm, "_fetch_stall"});
            cyc++;
        end
        step(1'b1, 6'($urandom), expect_cw(P_FETCH, op, 1'b1), {nm, "_fetch"});
        cyc++;
        step(1'($urandom), op, expect_cw(P_DEC, op, 1'b0), {nm, "_decode"});
        cyc++;
        tail(op, q);
        foreach (q[k]) begin
            if (q[k] == P_RD || q[k] == P_WR) begin
                for (int i = 0; i < mst; i++) begin
                    step(1'b0, 6'($urandom), expect_cw(q[k], op, 1'b0), {nm, "_mem_stall"});
                    cyc++;
                end
                step(1'b1, 6'($urandom), expect_cw(q[k], op, 1'b1), {nm, "_mem"});
            end else begin
                step(1'($urandom), 6'($urandom), expect_cw(q[k], op, 1'b0),
                     $sformatf("%s_ph%0d", nm, k));
            end
            cyc++;
        end
    endtask

    typedef struct {
        logic [5:0] op;
        int         fst;
        int         mst;
        int         cycles;
    } vec_t;

    vec_t tbl[12];
    logic [5:0] legal[8];
    int cyc;

    initial begin
        tbl[0]  = '{6'b000000, 0, 0, 4};
        tbl[1]  = '{6'b100011, 0, 3, 8};
        tbl[2]  = '{6'b101011, 0, 0, 4};
        tbl[3]  = '{6'b001101, 0, 0, 4};
        tbl[4]  = '{6'b001000, 0, 0, 4};
        tbl[5]  = '{6'b001100, 0, 0, 4};
        tbl[6]  = '{6'b000100, 0, 0, 3};
        tbl[7]  = '{6'b000010, 0, 0, 3};
        tbl[8]  = '{6'b111111, 0, 0, 3};
        tbl[9]  = '{6'b100011, 2, 0, 7};
        tbl[10] = '{6'b101011, 0, 2, 6};
        tbl[11] = '{6'b000000, 1, 0, 5};
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000010, 6'b001000, 6'b001100, 6'b001101};

        reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
        @(posedge clk); #1;
        check("in_reset", act, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1'b1, 6'($urandom), '0, "idle");

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].fst, tbl[i].mst, cyc);
            check_int($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cycles);
        end

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int fst, mst, exp_c;
            op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 7)];
            fst = $urandom_range(0, 2);
            mst = $urandom_range(0, 3);
            exp_c = base_cycles(op) + fst +
                    ((op == 6'b100011 || op == 6'b101011) ? mst : 0);
            run_instr(op, fst, mst, cyc);
            check_int($sformatf("rand%0d_cycles", n), cyc, exp_c);
        end

        // reset asserted in the middle of a MEMWRITE stall
        step(1'b1, 6'b000000, expect_cw(P_FETCH, 6'b0, 1'b1), "rst_fetch");
        step(1'b0, 6'b101011, expect_cw(P_DEC, 6'b0, 1'b0), "rst_decode");
        step(1'b1, 6'b000000, expect_cw(P_ADDR, 6'b0, 1'b0), "rst_addr");
        step(1'b0, 6'b000000, expect_cw(P_WR, 6'b0, 1'b0), "rst_wr_stall");
        mem_ready = 1'b0;
        #2;
        check("rst_wr_stall2", act, expect_cw(P_WR, 6'b0, 1'b0));
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_drop", act, '0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_held", act, '0);
        reset_n = 1'b1;
        step(1'b1, 6'b101011, '0, "rst_idle");
        run_instr(6'b000000, 0, 0, cyc);
        check_int("post_rst_cycles", cyc, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
